// File: rtl/int_ctrl.sv
// 8051 interrupt controller: latches the five sources, arbitrates with IE/IP and
// two-level nesting, and tracks in-service levels until RETI.
module int_ctrl #(
  parameter logic [15:0] VEC_BASE = 16'h0003,
  parameter int unsigned VEC_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int0_n,
  input  logic        int1_n,
  input  logic        tf0,
  input  logic        tf1,
  input  logic        ri_ti,
  input  logic [7:0]  ie,
  input  logic [4:0]  ip,
  input  logic        it0,
  input  logic        it1,
  input  logic        int_ack,
  input  logic        reti,
  output logic        int_req,
  output logic [15:0] int_vector,
  output logic [2:0]  int_src,
  output logic        clr_tf0,
  output logic        clr_tf1,
  output logic [1:0]  in_service
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  ext0_sh_q, ext1_sh_q;
  logic        ie0f_q, ie0f_d, ie1f_q, ie1f_d;
  logic        req_q, req_d;
  logic [2:0]  src_q, src_d;
  logic [15:0] vec_q, vec_d;
  logic        lvl_q, lvl_d;
  logic [1:0]  isv_q, isv_d;
  logic        clr0_q, clr0_d, clr1_q, clr1_d;

  logic        fall0, fall1, ack_fire, clr_ie0, clr_ie1;
  logic [4:0]  flag, pend, hi, lo;
  logic        elig, sel_lvl;
  logic [2:0]  sel_src;
  logic        unused_ie;

  assign unused_ie = ^ie[6:5];

  function automatic logic [2:0] lowest(input logic [4:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 5; i > 0; i--) begin
      if (v[i-1]) r = 3'(i - 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] vec_of(input logic [2:0] s);
    return VEC_BASE + 16'(VEC_STEP) * {13'b0, s};
  endfunction

  // Shift order: [0] first sync stage, [1] synchronized pin, [2] previous value.
  assign fall0 = ext0_sh_q[2] & ~ext0_sh_q[1];
  assign fall1 = ext1_sh_q[2] & ~ext1_sh_q[1];

  // A fresh edge counts in the same cycle it is detected, ahead of the latched flag.
  assign flag[0] = it0 ? (ie0f_q | fall0) : ~ext0_sh_q[1];
  assign flag[1] = tf0;
  assign flag[2] = it1 ? (ie1f_q | fall1) : ~ext1_sh_q[1];
  assign flag[3] = tf1;
  assign flag[4] = ri_ti;

  assign pend = flag & ie[4:0] & {5{ie[7]}};
  assign hi   = pend & ip;
  assign lo   = pend & ~ip;

  always_comb begin
    elig    = 1'b0;
    sel_src = '0;
    sel_lvl = 1'b0;
    if (hi != '0 && !isv_q[1]) begin
      elig    = 1'b1;
      sel_src = lowest(hi);
      sel_lvl = 1'b1;
    end else if (lo != '0 && isv_q == 2'b00) begin
      elig    = 1'b1;
      sel_src = lowest(lo);
      sel_lvl = 1'b0;
    end
  end

  assign ack_fire = (state_q == S_REQ) && int_ack;
  assign clr_ie0  = ack_fire && (src_q == 3'd0);
  assign clr_ie1  = ack_fire && (src_q == 3'd2);

  assign ie0f_d = it0 ? (fall0 | (ie0f_q & ~clr_ie0)) : ~ext0_sh_q[1];
  assign ie1f_d = it1 ? (fall1 | (ie1f_q & ~clr_ie1)) : ~ext1_sh_q[1];

  assign clr0_d = ack_fire && (src_q == 3'd1);
  assign clr1_d = ack_fire && (src_q == 3'd3);

  // RETI releases the innermost level before an ack in the same cycle sets its own.
  always_comb begin
    isv_d = isv_q;
    if (reti) begin
      if (isv_d[1]) isv_d[1] = 1'b0;
      else          isv_d[0] = 1'b0;
    end
    if (ack_fire) isv_d[lvl_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    src_d   = src_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    case (state_q)
      S_IDLE: begin
        if (elig) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          src_d   = sel_src;
          vec_d   = vec_of(sel_src);
          lvl_d   = sel_lvl;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_d = S_ACK;
          req_d   = 1'b0;
        end else if (elig) begin
          src_d = sel_src;
          vec_d = vec_of(sel_src);
          lvl_d = sel_lvl;
        end else begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ext0_sh_q <= '1;
      ext1_sh_q <= '1;
      ie0f_q    <= 1'b0;
      ie1f_q    <= 1'b0;
      req_q     <= 1'b0;
      src_q     <= '0;
      vec_q     <= VEC_BASE;
      lvl_q     <= 1'b0;
      isv_q     <= '0;
      clr0_q    <= 1'b0;
      clr1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext0_sh_q <= {ext0_sh_q[1:0], int0_n};
      ext1_sh_q <= {ext1_sh_q[1:0], int1_n};
      ie0f_q    <= ie0f_d;
      ie1f_q    <= ie1f_d;
      req_q     <= req_d;
      src_q     <= src_d;
      vec_q     <= vec_d;
      lvl_q     <= lvl_d;
      isv_q     <= isv_d;
      clr0_q    <= clr0_d;
      clr1_q    <= clr1_d;
    end
  end

  assign int_req    = req_q;
  assign int_vector = vec_q;
  assign int_src    = src_q;
  assign clr_tf0    = clr0_q;
  assign clr_tf1    = clr1_q;
  assign in_service = isv_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: inputs driven and outputs checked on the falling edge.
module tb_int_ctrl;

  logic        clk, rst;
  logic        int0_n, int1_n, tf0, tf1, ri_ti;
  logic [7:0]  ie;
  logic [4:0]  ip;
  logic        it0, it1, int_ack, reti;
  logic        int_req;
  logic [15:0] int_vector;
  logic [2:0]  int_src;
  logic        clr_tf0, clr_tf1;
  logic [1:0]  in_service;

  int n_assert = 0;
  int n_fail   = 0;

  int_ctrl #(.VEC_BASE(16'h0003), .VEC_STEP(8)) dut (
    .clk(clk), .rst(rst), .int0_n(int0_n), .int1_n(int1_n),
    .tf0(tf0), .tf1(tf1), .ri_ti(ri_ti), .ie(ie), .ip(ip),
    .it0(it0), .it1(it1), .int_ack(int_ack), .reti(reti),
    .int_req(int_req), .int_vector(int_vector), .int_src(int_src),
    .clr_tf0(clr_tf0), .clr_tf1(clr_tf1), .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [15:0] v, input logic [2:0] s);
    chk({tag, "_req"}, 16'(int_req), 16'(r));
    if (r) begin
      chk({tag, "_vec"}, int_vector, v);
      chk({tag, "_src"}, 16'(int_src), 16'(s));
    end
  endtask

  initial begin
    rst = 1'b1; int0_n = 1'b1; int1_n = 1'b1; tf0 = 1'b0; tf1 = 1'b0; ri_ti = 1'b0;
    ie = 8'h00; ip = 5'b00000; it0 = 1'b0; it1 = 1'b0; int_ack = 1'b0; reti = 1'b0;
    step(2);
    chk("rst_req", 16'(int_req), 16'd0);
    chk("rst_vec", int_vector, 16'h0003);
    chk("rst_src", 16'(int_src), 16'd0);
    chk("rst_clr", {14'd0, clr_tf1, clr_tf0}, 16'd0);
    chk("rst_isv", 16'(in_service), 16'd0);
    rst = 1'b0;
    step; chk_req("idle", 1'b0, 16'h0, 3'd0);

    // tf0 low priority
    ie = 8'h82; tf0 = 1'b1;
    step; chk_req("t1", 1'b1, 16'h000B, 3'd1);
    int_ack = 1'b1; step; int_ack = 1'b0;
    chk("t1_clr0", 16'(clr_tf0), 16'd1);
    chk("t1_isv", 16'(in_service), 16'd1);
    chk("t1_req_a", 16'(int_req), 16'd0);
    tf0 = 1'b0;
    step; chk("t1_clr0_pulse", 16'(clr_tf0), 16'd0); chk("t1_req_b", 16'(int_req), 16'd0);
    step; chk("t1_req_c", 16'(int_req), 16'd0);
    reti = 1'b1; step; reti = 1'b0;
    chk("t1_reti", 16'(in_service), 16'd0);
    ie = 8'h00;

    // ext0 edge, ext1 level
    ie = 8'h85; it0 = 1'b1; it1 = 1'b0;
    step; chk("t2_quiet", 16'(int_req), 16'd0);
    int0_n = 1'b0;
    step; chk("t2_lat1", 16'(int_req), 16'd0);
    step; chk("t2_lat2", 16'(int_req), 16'd0);
    step; chk_req("t2_ext0", 1'b1, 16'h0003, 3'd0);
    int_ack = 1'b1; int1_n = 1'b0; step; int_ack = 1'b0; int0_n = 1'b1;
    chk("t2_isv", 16'(in_service), 16'd1);
    chk("t2_req_a", 16'(int_req), 16'd0);
    step(5); chk("t2_blocked", 16'(int_req), 16'd0);
    reti = 1'b1; step; reti = 1'b0;
    chk("t2_reti", 16'(in_service), 16'd0);
    step; chk_req("t2_ext1", 1'b1, 16'h0013, 3'd2);
    int_ack = 1'b1; int1_n = 1'b1; step; int_ack = 1'b0;
    chk("t2_isv2", 16'(in_service), 16'd1);
    chk("t2_noclr", {14'd0, clr_tf1, clr_tf0}, 16'd0);
    step(4);
    reti = 1'b1; step; reti = 1'b0;
    chk("t2_reti2", 16'(in_service), 16'd0);
    step; chk("t2_edge_cleared", 16'(int_req), 16'd0);
    ie = 8'h00; it0 = 1'b0;

    // tf1 low, serial high preempts
    ie = 8'h88; tf1 = 1'b1;
    step; chk_req("t3_tf1", 1'b1, 16'h001B, 3'd3);
    int_ack = 1'b1; step; int_ack = 1'b0;
    chk("t3_clr1", 16'(clr_tf1), 16'd1);
    chk("t3_isv", 16'(in_service), 16'd1);
    tf1 = 1'b0; ip = 5'b10000; ri_ti = 1'b1; ie = 8'h98;
    step; chk("t3_dead", 16'(int_req), 16'd0); chk("t3_clr1_pulse", 16'(clr_tf1), 16'd0);
    step; chk_req("t3_ser", 1'b1, 16'h0023, 3'd4);
    int_ack = 1'b1; step; int_ack = 1'b0;
    chk("t3_isv11", 16'(in_service), 16'd3);
    chk("t3_ser_noclr", {14'd0, clr_tf1, clr_tf0}, 16'd0);
    step(3); chk("t3_nest_block", 16'(int_req), 16'd0);
    ri_ti = 1'b0; reti = 1'b1; step; reti = 1'b0;
    chk("t3_reti_hi", 16'(in_service), 16'd1);
    reti = 1'b1; step; reti = 1'b0;
    chk("t3_reti_lo", 16'(in_service), 16'd0);
    ie = 8'h00; ip = 5'b00000;

    // ext0 low level vs tf0 high
    it0 = 1'b0; int0_n = 1'b0;
    step(3); chk("t4_quiet", 16'(int_req), 16'd0);
    ip = 5'b00010; ie = 8'h83; tf0 = 1'b1;
    step; chk_req("t4_hi_first", 1'b1, 16'h000B, 3'd1);
    step; chk_req("t4_hold", 1'b1, 16'h000B, 3'd1);
    ie = 8'h03;
    step; chk("t5_ea_drop", 16'(int_req), 16'd0);
    step; chk("t5_idle", 16'(int_req), 16'd0);
    ie = 8'h83;
    step; chk("t5_rereq", 16'(int_req), 16'd1);
    rst = 1'b1; int_ack = 1'b1;
    step;
    chk("t5_rst_req", 16'(int_req), 16'd0);
    chk("t5_rst_vec", int_vector, 16'h0003);
    chk("t5_rst_src", 16'(int_src), 16'd0);
    chk("t5_rst_isv", 16'(in_service), 16'd0);
    chk("t5_rst_clr", 16'(clr_tf0), 16'd0);
    rst = 1'b0; int_ack = 1'b0;
    step; chk_req("t5_after_rst", 1'b1, 16'h000B, 3'd1);
    int_ack = 1'b1; step; int_ack = 1'b0;
    chk("t4_isv10", 16'(in_service), 16'd2);
    chk("t4_clr0", 16'(clr_tf0), 16'd1);
    tf0 = 1'b0;
    step(3); chk("t4_lo_blocked", 16'(int_req), 16'd0);
    reti = 1'b1; step; reti = 1'b0;
    chk("t4_reti", 16'(in_service), 16'd0);
    step; chk_req("t4_ext0", 1'b1, 16'h0003, 3'd0);
    int_ack = 1'b1; step; int_ack = 1'b0;
    chk("t4_isv01", 16'(in_service), 16'd1);
    tf0 = 1'b1;
    step; chk("t4_dead", 16'(int_req), 16'd0);
    step; chk_req("t4_preempt", 1'b1, 16'h000B, 3'd1);

    // reti and ack together: reti releases bit0, ack sets bit1
    int_ack = 1'b1; reti = 1'b1; step; int_ack = 1'b0; reti = 1'b0;
    chk("t6_isv", 16'(in_service), 16'd2);
    chk("t6_clr0", 16'(clr_tf0), 16'd1);
    tf0 = 1'b0; int0_n = 1'b1;
    step(3);
    reti = 1'b1; step; reti = 1'b0;
    chk("t6_reti", 16'(in_service), 16'd0);
    step(3); chk("t6_quiet", 16'(int_req), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
